debounce_bus: RTL and testbench
===============================

# debounce_bus

Multi-channel successor to the single-input debouncer: G_NUM_CH independent asynchronous inputs (buttons, switches, slow control strobes) are optionally synchronised, qualified by a minimum run length per edge direction, and locked out for a programmable time after each accepted edge. Each channel drives a debounced level plus single-cycle rise/fall pulses. The block sits directly behind the FPGA input pads and feeds control logic in the `clk` domain.

## Interface
- G_NUM_CH, 4: number of independent channels, ≥1.
- G_RISING_EDGE_MIN_COUNT, 16: consecutive high samples required to accept a rising edge, ≥1.
- G_FALLING_EDGE_MIN_COUNT, 16: consecutive low samples required to accept a falling edge, ≥1.
- G_POST_RISING_EDGE_DELAY, 256: lockout cycles after an accepted rising edge, ≥0.
- G_POST_FALLING_EDGE_DELAY, 256: lockout cycles after an accepted falling edge, ≥0.
- G_RESET_LEVEL, 0: debounced level and idle state of every channel at reset (0 or 1).
- clk  in  1  single clock; all logic is on its rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- din_bounce  in  G_NUM_CH  raw per-channel inputs, asynchronous to clk.
- dout_debounced  out  G_NUM_CH  debounced levels.
- rise_pulse  out  G_NUM_CH  one-cycle pulse on each accepted rising edge.
- fall_pulse  out  G_NUM_CH  one-cycle pulse on each accepted falling edge.

## Operation
- Channels are fully independent; simultaneous activity on any channels never interacts.
- Per-channel FSM: IDLE_LOW, QUAL_RISE, HOLD_HIGH, IDLE_HIGH, QUAL_FALL, HOLD_LOW.
- IDLE_LOW: sample high → cnt=1; if MIN_RISE=1 accept immediately, else QUAL_RISE.
- QUAL_RISE: sample high → cnt+1; when cnt reaches G_RISING_EDGE_MIN_COUNT, accept. Sample low → IDLE_LOW, cnt=0 (a glitch shorter than the minimum count never changes outputs).
- Accept rise: dout_debounced←1 and rise_pulse=1 on the same edge; enter HOLD_HIGH with cnt=0, or IDLE_HIGH directly if G_POST_RISING_EDGE_DELAY=0.
- HOLD_HIGH: input ignored; after G_POST_RISING_EDGE_DELAY cycles → IDLE_HIGH. If input is already low on the first IDLE_HIGH cycle, falling qualification starts that cycle.
- IDLE_HIGH / QUAL_FALL / HOLD_LOW mirror the rising path with the falling parameters, fall_pulse and dout←0.
- Counter width: $clog2(max of all four count/delay parameters + 1), shared by qualification and lockout.
- Reset (any time, including mid-qualification or mid-lockout): all channels go to IDLE_LOW (G_RESET_LEVEL=0) or IDLE_HIGH (=1), cnt=0, synchroniser flops cleared to G_RESET_LEVEL; no pulse is generated on reset release.

## Timing
- Reset values: dout_debounced={G_NUM_CH{G_RESET_LEVEL}}, rise_pulse=0, fall_pulse=0.
- All outputs registered. Pulses last exactly one cycle.
- Let S=2 with synchroniser, S=0 without. A stable input change captured at edge E0 updates dout and pulse at edge E0+S+MIN−1 (MIN=16, S=2: E0+17).
- Minimum spacing between two accepted edges on one channel: DELAY+MIN cycles of the opposite direction.

## Configuration
- DEBOUNCE_BUS_SYNC_EN defined: two-flop synchroniser per channel ahead of the FSM, S=2.
- Not defined: FSM samples din_bounce directly (inputs must already be synchronous to clk), S=0.

## Structure
- Package debounce_pkg: state_t enum (six states above) and a function computing counter width from parameters.
- Sub-module debounce_channel: one FSM + counter + optional synchroniser; debounce_bus instantiates G_NUM_CH copies with a generate loop.

## Test plan
All with G_NUM_CH=4, MIN counts 4, delays 8, sync enabled, G_RESET_LEVEL=0.
- Reset then hold ch0 high from edge E0 → dout[0] and rise_pulse[0] high at E0+5, pulse low at E0+6; other channels stay 0.
- ch1 glitch high for 3 cycles → dout[1], rise_pulse[1] unchanged (0).
- ch2 accepted rise, then bounce low/high every cycle for 8 cycles → no fall_pulse, dout[2] stays 1.
- ch3 rise accepted, input goes low during lockout and stays → fall accepted exactly 8+4 cycles after rise (MIN after lockout end).
- All four channels toggle simultaneously → four simultaneous rise_pulses, identical latency.
- Assert aresetn low mid-QUAL_RISE and mid-HOLD_HIGH → outputs 0 immediately; release with input low → no pulses. Rerun with G_RESET_LEVEL=1 → dout all 1 after reset, no fall_pulse.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types for the multi-channel debouncer: per-channel state encoding and
// the width of the counter shared by qualification and lockout.
package debounce_pkg;

  typedef enum logic [2:0] {
    IDLE_LOW,
    QUAL_RISE,
    HOLD_HIGH,
    IDLE_HIGH,
    QUAL_FALL,
    HOLD_LOW
  } state_t;

  function automatic int cnt_width(input int rise_min, input int fall_min,
                                   input int rise_dly, input int fall_dly);
    int m;
    m = rise_min;
    if (fall_min > m) m = fall_min;
    if (rise_dly > m) m = rise_dly;
    if (fall_dly > m) m = fall_dly;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: optional two-flop synchroniser (DEBOUNCE_BUS_SYNC_EN),
// run-length qualification per edge direction and a post-edge lockout timer.
//
// state     | meaning
// IDLE_LOW  | level 0, waiting for the first high sample
// QUAL_RISE | counting consecutive high samples
// HOLD_HIGH | level 1 just accepted, input ignored during lockout
// IDLE_HIGH | level 1, waiting for the first low sample
// QUAL_FALL | counting consecutive low samples
// HOLD_LOW  | level 0 just accepted, input ignored during lockout
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int G_RISING_EDGE_MIN_COUNT   = 16,
  parameter int G_FALLING_EDGE_MIN_COUNT  = 16,
  parameter int G_POST_RISING_EDGE_DELAY  = 256,
  parameter int G_POST_FALLING_EDGE_DELAY = 256,
  parameter int G_RESET_LEVEL             = 0
) (
  input  logic clk,
  input  logic aresetn,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(G_RISING_EDGE_MIN_COUNT, G_FALLING_EDGE_MIN_COUNT,
                                G_POST_RISING_EDGE_DELAY, G_POST_FALLING_EDGE_DELAY);
  localparam logic RL = (G_RESET_LEVEL != 0);
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] RISE_MIN  = CW'(G_RISING_EDGE_MIN_COUNT);
  localparam logic [CW-1:0] FALL_MIN  = CW'(G_FALLING_EDGE_MIN_COUNT);
  localparam logic [CW-1:0] RISE_LAST =
    CW'((G_POST_RISING_EDGE_DELAY > 0) ? G_POST_RISING_EDGE_DELAY - 1 : 0);
  localparam logic [CW-1:0] FALL_LAST =
    CW'((G_POST_FALLING_EDGE_DELAY > 0) ? G_POST_FALLING_EDGE_DELAY - 1 : 0);
  localparam state_t AFTER_RISE = (G_POST_RISING_EDGE_DELAY == 0) ? IDLE_HIGH : HOLD_HIGH;
  localparam state_t AFTER_FALL = (G_POST_FALLING_EDGE_DELAY == 0) ? IDLE_LOW : HOLD_LOW;
  localparam state_t RST_STATE  = RL ? IDLE_HIGH : IDLE_LOW;

  logic sample;

`ifdef DEBOUNCE_BUS_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) sync_q <= {2{RL}};
    else          sync_q <= {sync_q[0], din};
  end

  assign sample = sync_q[1];
`else
  assign sample = din;
`endif

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;
  logic            dout_nxt, rise_nxt, fall_nxt;

  assign cnt_inc = cnt + ONE;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= RST_STATE;
      cnt   <= '0;
      dout  <= RL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      dout  <= dout_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dout_nxt  = dout;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      IDLE_LOW, QUAL_RISE: begin
        if (sample) begin
          // idle behaves as a qualifier whose count is still zero
          if (((state == IDLE_LOW) ? ONE : cnt_inc) == RISE_MIN) begin
            dout_nxt  = 1'b1;
            rise_nxt  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = AFTER_RISE;
          end else begin
            cnt_nxt   = (state == IDLE_LOW) ? ONE : cnt_inc;
            state_nxt = QUAL_RISE;
          end
        end else begin
          cnt_nxt   = '0;
          state_nxt = IDLE_LOW;
        end
      end
      HOLD_HIGH: begin
        if (cnt == RISE_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE_HIGH;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      IDLE_HIGH, QUAL_FALL: begin
        if (!sample) begin
          if (((state == IDLE_HIGH) ? ONE : cnt_inc) == FALL_MIN) begin
            dout_nxt  = 1'b0;
            fall_nxt  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = AFTER_FALL;
          end else begin
            cnt_nxt   = (state == IDLE_HIGH) ? ONE : cnt_inc;
            state_nxt = QUAL_FALL;
          end
        end else begin
          cnt_nxt   = '0;
          state_nxt = IDLE_HIGH;
        end
      end
      HOLD_LOW: begin
        if (cnt == FALL_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE_LOW;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        cnt_nxt   = '0;
        dout_nxt  = RL;
        state_nxt = RST_STATE;
      end
    endcase
  end

endmodule

// File: rtl/debounce_bus.sv
// G_NUM_CH independent debounce channels behind the input pads.
// Define DEBOUNCE_BUS_SYNC_EN to add a two-flop synchroniser per channel.
module debounce_bus #(
  parameter int G_NUM_CH                  = 4,
  parameter int G_RISING_EDGE_MIN_COUNT   = 16,
  parameter int G_FALLING_EDGE_MIN_COUNT  = 16,
  parameter int G_POST_RISING_EDGE_DELAY  = 256,
  parameter int G_POST_FALLING_EDGE_DELAY = 256,
  parameter int G_RESET_LEVEL             = 0
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic [G_NUM_CH-1:0] din_bounce,
  output logic [G_NUM_CH-1:0] dout_debounced,
  output logic [G_NUM_CH-1:0] rise_pulse,
  output logic [G_NUM_CH-1:0] fall_pulse
);

  for (genvar i = 0; i < G_NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .G_RISING_EDGE_MIN_COUNT  (G_RISING_EDGE_MIN_COUNT),
      .G_FALLING_EDGE_MIN_COUNT (G_FALLING_EDGE_MIN_COUNT),
      .G_POST_RISING_EDGE_DELAY (G_POST_RISING_EDGE_DELAY),
      .G_POST_FALLING_EDGE_DELAY(G_POST_FALLING_EDGE_DELAY),
      .G_RESET_LEVEL            (G_RESET_LEVEL)
    ) u_ch (
      .clk     (clk),
      .aresetn (aresetn),
      .din     (din_bounce[i]),
      .dout    (dout_debounced[i]),
      .rise    (rise_pulse[i]),
      .fall    (fall_pulse[i])
    );
  end

endmodule

// File: tb/tb_debounce_bus.sv
// Bench for debounce_bus: two instances (reset level 0 and 1) on shared inputs,
// checked every cycle against a timestamp-based model plus directed literal checks.
module tb_debounce_bus;

  localparam int NCH  = 4;
  localparam int MINR = 4;
  localparam int MINF = 4;
  localparam int DLYR = 8;
  localparam int DLYF = 8;
`ifdef DEBOUNCE_BUS_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif
  localparam int LAT = S + MINR - 1;

  logic           clk = 1'b0;
  logic           aresetn;
  logic [NCH-1:0] din;
  logic [NCH-1:0] d0, r0, f0, d1, r1, f1;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int rise_seen0 = 0, fall_seen0 = 0, fall_seen1 = 0;

  debounce_bus #(
    .G_NUM_CH(NCH), .G_RISING_EDGE_MIN_COUNT(MINR), .G_FALLING_EDGE_MIN_COUNT(MINF),
    .G_POST_RISING_EDGE_DELAY(DLYR), .G_POST_FALLING_EDGE_DELAY(DLYF), .G_RESET_LEVEL(0)
  ) dut0 (
    .clk(clk), .aresetn(aresetn), .din_bounce(din),
    .dout_debounced(d0), .rise_pulse(r0), .fall_pulse(f0)
  );

  debounce_bus #(
    .G_NUM_CH(NCH), .G_RISING_EDGE_MIN_COUNT(MINR), .G_FALLING_EDGE_MIN_COUNT(MINF),
    .G_POST_RISING_EDGE_DELAY(DLYR), .G_POST_FALLING_EDGE_DELAY(DLYF), .G_RESET_LEVEL(1)
  ) dut1 (
    .clk(clk), .aresetn(aresetn), .din_bounce(din),
    .dout_debounced(d1), .rise_pulse(r1), .fall_pulse(f1)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: a new level is accepted once MIN consecutive opposite-level samples
  // have been seen, counting only samples taken after the lockout window ends.
  bit m_lvl [2][NCH];
  bit m_rp  [2][NCH];
  bit m_fp  [2][NCH];
  bit p1    [2][NCH];
  bit p2    [2][NCH];
  int m_run [2][NCH];
  int m_lock[2][NCH];
  int mt = 0;

  initial forever begin
    @(posedge clk or negedge aresetn);
    if (!aresetn) begin
      mt = 0;
      for (int i = 0; i < 2; i++)
        for (int c = 0; c < NCH; c++) begin
          m_lvl[i][c]  = (i == 1);
          p1[i][c]     = (i == 1);
          p2[i][c]     = (i == 1);
          m_rp[i][c]   = 1'b0;
          m_fp[i][c]   = 1'b0;
          m_run[i][c]  = 0;
          m_lock[i][c] = -1;
        end
    end else begin
      mt++;
      for (int i = 0; i < 2; i++)
        for (int c = 0; c < NCH; c++) begin
          bit s;
          s = (S == 2) ? p2[i][c] : din[c];
          p2[i][c] = p1[i][c];
          p1[i][c] = din[c];
          m_rp[i][c] = 1'b0;
          m_fp[i][c] = 1'b0;
          if (mt > m_lock[i][c] && s != m_lvl[i][c]) begin
            m_run[i][c]++;
            if (m_run[i][c] >= (s ? MINR : MINF)) begin
              m_lvl[i][c]  = s;
              m_rp[i][c]   = s;
              m_fp[i][c]   = !s;
              m_run[i][c]  = 0;
              m_lock[i][c] = mt + (s ? DLYR : DLYF);
            end
          end else begin
            m_run[i][c] = 0;
          end
        end
    end
  end

  initial forever begin
    logic [NCH-1:0] ed, er, ef;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < NCH; c++) begin
        ed[c] = m_lvl[i][c];
        er[c] = m_rp[i][c];
        ef[c] = m_fp[i][c];
      end
      chk($sformatf("model dout inst%0d", i), 32'((i == 0) ? d0 : d1), 32'(ed));
      chk($sformatf("model rise inst%0d", i), 32'((i == 0) ? r0 : r1), 32'(er));
      chk($sformatf("model fall inst%0d", i), 32'((i == 0) ? f0 : f1), 32'(ef));
    end
    if (r0 != 0) rise_seen0++;
    if (f0 != 0) fall_seen0++;
    if (f1 != 0) fall_seen1++;
  end

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int e, a;
    int hold[NCH];
    aresetn = 1'b0;
    din     = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset dout0", 32'(d0), 32'h0);
    chk("reset rise0", 32'(r0), 32'h0);
    chk("reset fall0", 32'(f0), 32'h0);
    chk("reset dout1", 32'(d1), 32'hF);
    @(negedge clk);
    aresetn = 1'b1;
    repeat (3) @(negedge clk);

    // ch0 stable high: latency S+MIN-1
    din[0] = 1'b1;
    e = cyc + 1;
    wait_to(e + LAT - 1);
    chk("ch0 dout before accept", 32'(d0[0]), 32'h0);
    wait_to(e + LAT);
    chk("ch0 dout at accept", 32'(d0[0]), 32'h1);
    chk("ch0 rise at accept", 32'(r0[0]), 32'h1);
    chk("ch0 others quiet", 32'(d0[3:1]), 32'h0);
    wait_to(e + LAT + 1);
    chk("ch0 rise one cycle", 32'(r0[0]), 32'h0);

    // ch1 glitch shorter than MIN
    @(negedge clk);
    rise_seen0 = 0;
    din[1] = 1'b1;
    repeat (3) @(negedge clk);
    din[1] = 1'b0;
    repeat (12) @(negedge clk);
    chk("ch1 glitch dout", 32'(d0[1]), 32'h0);
    chk("ch1 glitch no rise", 32'(rise_seen0), 32'h0);

    // ch2 accept then bounce inside lockout
    din[2] = 1'b1;
    e = cyc + 1;
    wait_to(e + LAT);
    chk("ch2 rise", 32'(r0[2]), 32'h1);
    fall_seen0 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      din[2] = i[0];
    end
    repeat (20) @(negedge clk);
    chk("ch2 bounce no fall", 32'(fall_seen0), 32'h0);
    chk("ch2 bounce dout", 32'(d0[2]), 32'h1);

    // ch3 low during lockout: fall exactly DELAY+MIN after rise
    din[3] = 1'b1;
    e = cyc + 1;
    a = e + LAT;
    wait_to(a);
    chk("ch3 rise", 32'(r0[3]), 32'h1);
    @(negedge clk);
    din[3] = 1'b0;
    wait_to(a + DLYR + MINF - 1);
    chk("ch3 fall early", 32'(f0[3]), 32'h0);
    chk("ch3 dout early", 32'(d0[3]), 32'h1);
    wait_to(a + DLYR + MINF);
    chk("ch3 fall on time", 32'(f0[3]), 32'h1);
    chk("ch3 dout on time", 32'(d0[3]), 32'h0);

    // all channels simultaneously
    @(negedge clk);
    din = '0;
    repeat (30) @(negedge clk);
    din = '1;
    e = cyc + 1;
    wait_to(e + LAT - 1);
    chk("simul rise early", 32'(r0), 32'h0);
    wait_to(e + LAT);
    chk("simul rise", 32'(r0), 32'hF);
    chk("simul dout", 32'(d0), 32'hF);

    // reset mid-qualification
    @(negedge clk);
    din = '0;
    repeat (30) @(negedge clk);
    din[0] = 1'b1;
    e = cyc + 1;
    wait_to(e + LAT - 1);
    @(negedge clk);
    aresetn = 1'b0;
    #1;
    chk("rst qual dout0", 32'(d0), 32'h0);
    chk("rst qual dout1", 32'(d1), 32'hF);
    din = '0;
    @(negedge clk);
    aresetn = 1'b1;
    rise_seen0 = 0;
    fall_seen0 = 0;
    repeat (20) @(negedge clk);
    chk("rst qual no rise", 32'(rise_seen0), 32'h0);
    chk("rst qual no fall", 32'(fall_seen0), 32'h0);

    // reset mid-lockout
    din = '1;
    e = cyc + 1;
    wait_to(e + LAT + 3);
    @(negedge clk);
    aresetn = 1'b0;
    #1;
    chk("rst hold dout0", 32'(d0), 32'h0);
    chk("rst hold rise0", 32'(r0), 32'h0);
    din = '0;
    @(negedge clk);
    aresetn = 1'b1;
    rise_seen0 = 0;
    fall_seen0 = 0;
    repeat (20) @(negedge clk);
    chk("rst hold no rise", 32'(rise_seen0), 32'h0);
    chk("rst hold no fall", 32'(fall_seen0), 32'h0);

    // reset level 1 with inputs high
    din = '1;
    aresetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("lvl1 reset dout", 32'(d1), 32'hF);
    aresetn = 1'b1;
    fall_seen1 = 0;
    repeat (20) @(negedge clk);
    chk("lvl1 no fall", 32'(fall_seen1), 32'h0);
    chk("lvl1 dout", 32'(d1), 32'hF);
    chk("lvl0 follows high", 32'(d0), 32'hF);

    // randomized runs of varying length, occasional reset
    for (int c = 0; c < NCH; c++) hold[c] = $urandom_range(1, 12);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          din[c]  = ~din[c];
          hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30)
                                                : $urandom_range(1, 8);
        end
      end
      aresetn = ($urandom_range(0, 399) != 0);
    end
    @(negedge clk);
    aresetn = 1'b1;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
